// File: rtl/z80_io_pkg.sv
// z80_io_pkg: shared write-FSM states, default port numbers and status-byte bit positions
package z80_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        HOLD  = 2'd2
    } wr_state_t;

    localparam logic [7:0] DEF_BASE_PORT = 8'h80;
    localparam logic [7:0] DEF_HALT_PORT = 8'hFF;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

endpackage

// File: rtl/z80_io_fifo.sv
// z80_io_fifo: synchronous byte FIFO feeding the console stream.
// Ports: clk/rst (async active-high), push/din write side, pop/dout read side,
//        full/empty flags and occupancy count (log2(DEPTH)+1 bits).
module z80_io_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;

    // Storage is deliberately not reset; only the pointers and count are.
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;

    // Pointers wrap modulo DEPTH by natural overflow (DEPTH is a power of two).
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= (push & ~pop) ? count + CW'(1) :
                     (pop & ~push) ? count - CW'(1) : count;
        end

endmodule

// File: rtl/z80_io_port.sv
// z80_io_port: Z80 I/O-space console port with output FIFO, status port and halt latch.
// Ports: CLK, CLR (async active-high reset); CPU side ADDR, DQ (tristate),
//        nIORQ/nRD/nWR/nM1 strobes, nWAIT stall; stream side TX_DATA/TX_VALID/TX_READY;
//        DONE/RESULT latched by the first halt-port write.
module z80_io_port import z80_io_pkg::*; #(
    parameter logic [7:0] BASE_PORT = DEF_BASE_PORT,
    parameter logic [7:0] HALT_PORT = DEF_HALT_PORT,
    parameter int         DEPTH     = 4
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [7:0] ADDR,
    inout  wire  [7:0] DQ,
    input  logic       nIORQ,
    input  logic       nRD,
    input  logic       nWR,
    input  logic       nM1,
    output logic       nWAIT,
    output logic [7:0] TX_DATA,
    output logic       TX_VALID,
    input  logic       TX_READY,
    output logic       DONE,
    output logic [7:0] RESULT
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          wsel, rsel, at_base, at_stat;
    logic          pop, push, full, empty, stall, ovf;
    logic [CW-1:0] count;
    logic [7:0]    status;
    wr_state_t     state;

    // nM1 low together with nIORQ is interrupt acknowledge, never a port access.
    assign wsel    = ~nIORQ & ~nWR & nM1;
    assign rsel    = ~nIORQ & ~nRD & nM1;
    assign at_base = ADDR == BASE_PORT;
    assign at_stat = ADDR == BASE_PORT + 8'd1;

    assign pop      = TX_READY & ~empty;
    assign TX_VALID = ~empty;

    // A same-edge pop frees the slot, so the stall drops combinationally
    // and the byte is pushed on that very edge. HOLD means the cycle already acted.
    assign stall = wsel & at_base & full & ~pop & (state != HOLD);
    assign push  = wsel & at_base & ~stall & (state != HOLD);
    assign nWAIT = ~stall;

    always_comb begin
        status                     = '0;
        status[ST_EMPTY]           = empty;
        status[ST_FULL]            = full;
        status[ST_OVF]             = ovf;
        status[ST_CNT_LSB +: 4]    = 4'(count);
    end

    assign DQ = (rsel & at_stat) ? status : 8'bz;

    z80_io_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (CLR),
        .push  (push),
        .pop   (pop),
        .din   (DQ),
        .dout  (TX_DATA),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge CLK or posedge CLR)
        if (CLR) begin
            state  <= IDLE;
            ovf    <= 1'b0;
            DONE   <= 1'b0;
            RESULT <= 8'h00;
        end else begin
            state <= (state == HOLD) ? (wsel ? HOLD : IDLE) :
                     ~wsel           ? IDLE :
                     stall           ? STALL : HOLD;
            // CPU abandoned a stalled write: the byte is lost, flag it.
            if (state == STALL && !wsel) ovf <= 1'b1;
            if (state == IDLE && wsel && ADDR == HALT_PORT && !DONE) begin
                DONE   <= 1'b1;
                RESULT <= DQ;
            end
        end

endmodule
